// File: rtl/ibex_dffram_arbiter.sv
// rtl/ibex_dffram_arbiter.sv - Ibex fetch/LSU arbiter onto a single-port DFFRAM macro.
// Optional DFFRAM_ARB_RR_EN: round-robin arbitration instead of fixed data-over-instr priority.
module ibex_dffram_arbiter #(
    parameter int          ADDR_W    = 12,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic              CLK,
    input  logic              RST,

    input  logic              instr_req_i,
    output logic              instr_gnt_o,
    input  logic [31:0]       instr_addr_i,
    output logic              instr_rvalid_o,
    output logic [31:0]       instr_rdata_o,
    output logic              instr_err_o,

    input  logic              data_req_i,
    output logic              data_gnt_o,
    input  logic [31:0]       data_addr_i,
    input  logic              data_we_i,
    input  logic [3:0]        data_be_i,
    input  logic [31:0]       data_wdata_i,
    output logic              data_rvalid_o,
    output logic [31:0]       data_rdata_o,
    output logic              data_err_o,

    output logic              ram_en_o,
    output logic [3:0]        ram_we_o,
    output logic [ADDR_W-1:0] ram_a_o,
    output logic [31:0]       ram_di_o,
    input  logic [31:0]       ram_do_i
);

    localparam int TAG_LSB = ADDR_W + 2;

    typedef enum logic {
        PORT_INSTR = 1'b0,
        PORT_DATA  = 1'b1
    } port_e;

    logic  instr_in_range;
    logic  data_in_range;
    logic  data_prio;
    logic  grant_instr;
    logic  grant_data;
    logic  any_grant;
    port_e winner;
    logic  win_in_range;
    logic  win_write;

    logic  resp_valid_q, resp_valid_d;
    port_e resp_port_q,  resp_port_d;
    logic  resp_err_q,   resp_err_d;
    logic  resp_read_q,  resp_read_d;

    logic        sel_instr;
    logic        sel_data;
    logic [31:0] resp_rdata;

    // Byte-offset bits never select anything in a word-wide RAM.
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^{instr_addr_i[1:0], data_addr_i[1:0]};

    assign instr_in_range = (instr_addr_i[31:TAG_LSB] == BASE_ADDR[31:TAG_LSB]);
    assign data_in_range  = (data_addr_i[31:TAG_LSB]  == BASE_ADDR[31:TAG_LSB]);

`ifdef DFFRAM_ARB_RR_EN
    port_e last_grant_q, last_grant_d;

    // On contention the port that did not win last time goes first.
    assign data_prio = (last_grant_q == PORT_INSTR);

    always_comb begin
        last_grant_d = last_grant_q;
        if (any_grant) begin
            last_grant_d = winner;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            last_grant_q <= PORT_DATA;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end
`else
    assign data_prio = 1'b1;
`endif

    // Grants are held off during reset so the core never sees a handshake then.
    assign grant_data  = data_req_i & ~RST & (~instr_req_i | data_prio);
    assign grant_instr = instr_req_i & ~RST & ~grant_data;
    assign any_grant   = grant_instr | grant_data;
    assign winner      = grant_data ? PORT_DATA : PORT_INSTR;

    assign win_in_range = grant_data ? data_in_range : instr_in_range;
    assign win_write    = grant_data & data_we_i;

    always_comb begin
        ram_en_o = any_grant & win_in_range;
        ram_we_o = 4'b0000;
        if (any_grant && win_in_range && win_write) begin
            ram_we_o = data_be_i;
        end
        ram_a_o  = grant_instr ? instr_addr_i[TAG_LSB-1:2] : data_addr_i[TAG_LSB-1:2];
        ram_di_o = data_wdata_i;
    end

    assign instr_gnt_o = grant_instr;
    assign data_gnt_o  = grant_data;

    always_comb begin
        resp_valid_d = any_grant;
        resp_port_d  = winner;
        resp_read_d  = ~win_write;
        resp_err_d   = any_grant & ~win_in_range;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            resp_valid_q <= 1'b0;
            resp_port_q  <= PORT_INSTR;
            resp_err_q   <= 1'b0;
            resp_read_q  <= 1'b0;
        end else begin
            resp_valid_q <= resp_valid_d;
            resp_port_q  <= resp_port_d;
            resp_err_q   <= resp_err_d;
            resp_read_q  <= resp_read_d;
        end
    end

    // Write and error responses carry no data; the RAM output is masked for them.
    assign sel_instr  = resp_valid_q & (resp_port_q == PORT_INSTR);
    assign sel_data   = resp_valid_q & (resp_port_q == PORT_DATA);
    assign resp_rdata = (resp_read_q && !resp_err_q) ? ram_do_i : 32'h0;

    assign instr_rvalid_o = sel_instr;
    assign instr_err_o    = sel_instr & resp_err_q;
    assign instr_rdata_o  = sel_instr ? resp_rdata : 32'h0;

    assign data_rvalid_o  = sel_data;
    assign data_err_o     = sel_data & resp_err_q;
    assign data_rdata_o   = sel_data ? resp_rdata : 32'h0;

endmodule

// File: tb/tb_ibex_dffram_arbiter.sv
// tb/tb_ibex_dffram_arbiter.sv - Vector table, corner sequences and random traffic against a reference model.
module tb_ibex_dffram_arbiter;

`ifdef DFFRAM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        instr_req_i = 1'b0;
    logic        instr_gnt_o;
    logic [31:0] instr_addr_i = 32'h0;
    logic        instr_rvalid_o;
    logic [31:0] instr_rdata_o;
    logic        instr_err_o;
    logic        data_req_i = 1'b0;
    logic        data_gnt_o;
    logic [31:0] data_addr_i = 32'h0;
    logic        data_we_i = 1'b0;
    logic [3:0]  data_be_i = 4'h0;
    logic [31:0] data_wdata_i = 32'h0;
    logic        data_rvalid_o;
    logic [31:0] data_rdata_o;
    logic        data_err_o;
    logic        ram_en_o;
    logic [3:0]  ram_we_o;
    logic [11:0] ram_a_o;
    logic [31:0] ram_di_o;
    logic [31:0] ram_do_i = 32'h0;

    always #5 CLK = ~CLK;

    ibex_dffram_arbiter #(.ADDR_W(12), .BASE_ADDR(32'h0)) dut (
        .CLK(CLK), .RST(RST),
        .instr_req_i(instr_req_i), .instr_gnt_o(instr_gnt_o), .instr_addr_i(instr_addr_i),
        .instr_rvalid_o(instr_rvalid_o), .instr_rdata_o(instr_rdata_o), .instr_err_o(instr_err_o),
        .data_req_i(data_req_i), .data_gnt_o(data_gnt_o), .data_addr_i(data_addr_i),
        .data_we_i(data_we_i), .data_be_i(data_be_i), .data_wdata_i(data_wdata_i),
        .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o), .data_err_o(data_err_o),
        .ram_en_o(ram_en_o), .ram_we_o(ram_we_o), .ram_a_o(ram_a_o),
        .ram_di_o(ram_di_o), .ram_do_i(ram_do_i)
    );

    // DFFRAM macro model with a preload port used only during reset.
    logic [31:0] mem [0:4095];
    logic        pl_we = 1'b0;
    logic [11:0] pl_a = 12'h0;
    logic [31:0] pl_d = 32'h0;

    always @(posedge CLK) begin
        if (pl_we) begin
            mem[pl_a] <= pl_d;
        end else if (ram_en_o) begin
            for (int b = 0; b < 4; b++) begin
                if (ram_we_o[b]) mem[ram_a_o][b*8 +: 8] <= ram_di_o[b*8 +: 8];
            end
            ram_do_i <= mem[ram_a_o];
        end
    end

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] ref_mem [0:63];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_outputs(input logic eig, input logic edg, input logic een,
                                 input logic [3:0] ewe, input logic [11:0] ea,
                                 input logic eirv, input logic edrv,
                                 input logic [31:0] erd, input logic eerr);
        chk("instr_gnt", {31'h0, instr_gnt_o}, {31'h0, eig});
        chk("data_gnt", {31'h0, data_gnt_o}, {31'h0, edg});
        chk("ram_en", {31'h0, ram_en_o}, {31'h0, een});
        chk("ram_we", {28'h0, ram_we_o}, {28'h0, ewe});
        if (een) chk("ram_a", {20'h0, ram_a_o}, {20'h0, ea});
        chk("instr_rvalid", {31'h0, instr_rvalid_o}, {31'h0, eirv});
        chk("data_rvalid", {31'h0, data_rvalid_o}, {31'h0, edrv});
        chk("instr_rdata", instr_rdata_o, eirv ? erd : 32'h0);
        chk("instr_err", {31'h0, instr_err_o}, {31'h0, eirv & eerr});
        chk("data_rdata", data_rdata_o, edrv ? erd : 32'h0);
        chk("data_err", {31'h0, data_err_o}, {31'h0, edrv & eerr});
    endtask

    typedef struct {
        logic        ireq;
        logic [31:0] iaddr;
        logic        dreq;
        logic [31:0] daddr;
        logic        dwe;
        logic [3:0]  dbe;
        logic [31:0] dwd;
        logic        eig, edg, een;
        logic [3:0]  ewe;
        logic [11:0] ea;
        logic        eirv, edrv;
        logic [31:0] erd;
        logic        eerr;
    } vec_t;

    function automatic vec_t row(input logic ireq, input logic [31:0] iaddr, input logic dreq,
                                 input logic [31:0] daddr, input logic dwe, input logic [3:0] dbe,
                                 input logic [31:0] dwd, input logic eig, input logic edg,
                                 input logic een, input logic [3:0] ewe, input logic [11:0] ea,
                                 input logic eirv, input logic edrv, input logic [31:0] erd,
                                 input logic eerr);
        vec_t v;
        v.ireq = ireq; v.iaddr = iaddr; v.dreq = dreq; v.daddr = daddr;
        v.dwe = dwe; v.dbe = dbe; v.dwd = dwd;
        v.eig = eig; v.edg = edg; v.een = een; v.ewe = ewe; v.ea = ea;
        v.eirv = eirv; v.edrv = edrv; v.erd = erd; v.eerr = eerr;
        return v;
    endfunction

    task automatic apply(input vec_t v);
        @(posedge CLK);
        #1;
        instr_req_i = v.ireq; instr_addr_i = v.iaddr;
        data_req_i = v.dreq; data_addr_i = v.daddr; data_we_i = v.dwe;
        data_be_i = v.dbe; data_wdata_i = v.dwd;
        @(negedge CLK);
        check_outputs(v.eig, v.edg, v.een, v.ewe, v.ea, v.eirv, v.edrv, v.erd, v.eerr);
    endtask

    function automatic logic [31:0] rand_addr();
        if ($urandom_range(0, 7) == 0) return $urandom | 32'h0000_4000;
        return $urandom_range(0, 63) * 4 + $urandom_range(0, 3);
    endfunction

    vec_t vecs[$];
    vec_t idle;

    // Random-traffic model state: outstanding requests held until granted, and the expected response.
    logic        ip_v, dp_v, dp_we, last_is_data;
    logic [31:0] ip_a, dp_a, dp_wd;
    logic [3:0]  dp_be;
    logic        pv_i, pv_d, p_err;
    logic [31:0] p_rd;

    initial begin
        for (int i = 0; i < 64; i++) ref_mem[i] = 32'h9E37_79B9 * (i + 1);
        ref_mem[0] = 32'hA0A0A0A0; ref_mem[1] = 32'hB1B1B1B1; ref_mem[2] = 32'hC2C2C2C2;
        ref_mem[4] = 32'hDEADBEEF; ref_mem[8] = 32'hFFFFFFFF;

        // Requests asserted during reset must not leak through.
        instr_req_i = 1'b1; data_req_i = 1'b1; data_we_i = 1'b1; data_be_i = 4'hF;
        @(negedge CLK);
        check_outputs(0, 0, 0, 4'h0, 12'h0, 0, 0, 32'h0, 0);
        instr_req_i = 1'b0; data_req_i = 1'b0; data_we_i = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(posedge CLK); #1;
            pl_we = 1'b1; pl_a = 12'(i); pl_d = ref_mem[i];
        end
        @(posedge CLK); #1;
        pl_we = 1'b0;
        RST = 1'b0;

        idle = row(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs.push_back(row(1, 32'h10, 0, 0, 0, 0, 0, 1, 0, 1, 0, 4, 0, 0, 0, 0));
        vecs.push_back(row(0, 0, 1, 32'h20, 1, 4'b0101, 32'h11223344, 0, 1, 1, 4'b0101, 8, 1, 0, 32'hDEADBEEF, 0));
        vecs.push_back(row(0, 0, 1, 32'h20, 0, 4'hF, 0, 0, 1, 1, 0, 8, 0, 1, 0, 0));
        vecs.push_back(row(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hFF22FF44, 0));
        vecs.push_back(row(0, 0, 1, 32'h4000, 0, 4'hF, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(row(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1));
        vecs.push_back(row(1, 32'h0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(row(0, 0, 1, 32'h4, 0, 4'hF, 0, 0, 1, 1, 0, 1, 1, 0, 32'hA0A0A0A0, 0));
        vecs.push_back(row(1, 32'h8, 0, 0, 0, 0, 0, 1, 0, 1, 0, 2, 0, 1, 32'hB1B1B1B1, 0));
        vecs.push_back(row(0, 0, 1, 32'h10, 0, 4'hF, 0, 0, 1, 1, 0, 4, 1, 0, 32'hC2C2C2C2, 0));
        if (RR) begin
            vecs.push_back(row(1, 0, 1, 4, 0, 4'hF, 0, 1, 0, 1, 0, 0, 0, 1, 32'hDEADBEEF, 0));
            vecs.push_back(row(1, 0, 1, 4, 0, 4'hF, 0, 0, 1, 1, 0, 1, 1, 0, 32'hA0A0A0A0, 0));
            vecs.push_back(row(1, 0, 1, 4, 0, 4'hF, 0, 1, 0, 1, 0, 0, 0, 1, 32'hB1B1B1B1, 0));
            vecs.push_back(row(1, 0, 1, 4, 0, 4'hF, 0, 0, 1, 1, 0, 1, 1, 0, 32'hA0A0A0A0, 0));
        end else begin
            vecs.push_back(row(1, 0, 1, 4, 0, 4'hF, 0, 0, 1, 1, 0, 1, 0, 1, 32'hDEADBEEF, 0));
            for (int i = 0; i < 3; i++)
                vecs.push_back(row(1, 0, 1, 4, 0, 4'hF, 0, 0, 1, 1, 0, 1, 0, 1, 32'hB1B1B1B1, 0));
        end
        vecs.push_back(row(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hB1B1B1B1, 0));
        foreach (vecs[i]) apply(vecs[i]);
        ref_mem[8] = 32'hFF22FF44;

        // Reset between a grant and its response drops the response.
        apply(row(0, 0, 1, 32'h4, 0, 4'hF, 0, 0, 1, 1, 0, 1, 0, 0, 0, 0));
        #1;
        RST = 1'b1; instr_req_i = 1'b1;
        #1;
        check_outputs(0, 0, 0, 4'h0, 12'h0, 0, 0, 32'h0, 0);
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check_outputs(0, 0, 0, 4'h0, 12'h0, 0, 0, 32'h0, 0);
        @(posedge CLK); #1;
        RST = 1'b0; instr_req_i = 1'b0; data_req_i = 1'b0;
        @(negedge CLK);
        check_outputs(0, 0, 0, 4'h0, 12'h0, 0, 0, 32'h0, 0);
        apply(row(1, 32'h10, 0, 0, 0, 0, 0, 1, 0, 1, 0, 4, 0, 0, 0, 0));
        apply(row(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'hDEADBEEF, 0));

        ip_v = 0; dp_v = 0; dp_we = 0; last_is_data = 0;
        ip_a = 0; dp_a = 0; dp_wd = 0; dp_be = 0;
        pv_i = 0; pv_d = 0; p_err = 0; p_rd = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            logic gi, gd, inr, een;
            logic [31:0] wa;
            logic [3:0]  ewe;
            @(posedge CLK); #1;
            if (!ip_v && $urandom_range(0, 2) != 0) begin
                ip_v = 1; ip_a = rand_addr();
            end
            if (!dp_v && $urandom_range(0, 2) != 0) begin
                dp_v = 1; dp_a = rand_addr(); dp_we = 1'($urandom);
                dp_be = 4'($urandom); dp_wd = $urandom;
            end
            instr_req_i = ip_v; instr_addr_i = ip_v ? ip_a : $urandom;
            data_req_i = dp_v; data_addr_i = dp_v ? dp_a : $urandom;
            data_we_i = dp_we; data_be_i = dp_be; data_wdata_i = dp_wd;
            @(negedge CLK);
            gd = (ip_v && dp_v) ? (RR ? !last_is_data : 1'b1) : dp_v;
            gi = ip_v && !gd;
            wa = gd ? dp_a : ip_a;
            inr = (wa / 32'h4000) == 0;
            een = (gi || gd) && inr;
            ewe = (een && gd && dp_we) ? dp_be : 4'h0;
            check_outputs(gi, gd, een, ewe, 12'(wa / 4), pv_i, pv_d, p_rd, p_err);
            pv_i = gi; pv_d = gd;
            p_err = (gi || gd) && !inr;
            p_rd = (een && !(gd && dp_we)) ? ref_mem[(wa / 4) % 64] : 32'h0;
            if (een && gd && dp_we)
                for (int b = 0; b < 4; b++)
                    if (dp_be[b]) ref_mem[(wa / 4) % 64][b*8 +: 8] = dp_wd[b*8 +: 8];
            if (gd) dp_v = 0;
            if (gi) ip_v = 0;
            if (gi || gd) last_is_data = gd;
        end
        @(posedge CLK); #1;
        instr_req_i = 0; data_req_i = 0;
        @(negedge CLK);
        check_outputs(0, 0, 0, 4'h0, 12'h0, pv_i, pv_d, p_rd, p_err);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ibex_dffram_arbiter.md
Name: ibex_dffram_arbiter

Overview:
- Bridges the Ibex core's instruction-fetch and load/store ports onto the single-port 16 KB DFFRAM macro.
- Arbitrates the two req/gnt/rvalid request streams, grants at most one per cycle and drives the RAM enable, write mask, address and data.
- Returns a response to the granted port on the following cycle, tracking the single outstanding transaction in flops.
- Flags out-of-window addresses as bus errors without touching the RAM.

Parameters:
ADDR_W, 12, RAM word-address width; window size = 4*2^ADDR_W bytes
BASE_ADDR, 32'h0000_0000, byte base of the RAM window; aligned to window size

Ports:
CLK  in  1  clock
RST  in  1  reset, asynchronous, active-high
instr_req_i  in  1  fetch request
instr_gnt_o  out  1  fetch grant
instr_addr_i  in  32  fetch byte address
instr_rvalid_o  out  1  fetch response valid
instr_rdata_o  out  32  fetch read data
instr_err_o  out  1  fetch error
data_req_i  in  1  LSU request
data_gnt_o  out  1  LSU grant
data_addr_i  in  32  LSU byte address
data_we_i  in  1  LSU write
data_be_i  in  4  LSU byte enables
data_wdata_i  in  32  LSU write data
data_rvalid_o  out  1  LSU response valid
data_rdata_o  out  32  LSU read data
data_err_o  out  1  LSU error
ram_en_o  out  1  RAM enable
ram_we_o  out  4  RAM byte write mask
ram_a_o  out  ADDR_W  RAM word address
ram_di_o  out  32  RAM write data
ram_do_i  in  32  RAM read data; valid one cycle after ram_en_o

Behaviour:
- Reset: async clears resp_valid, resp_port, resp_err, resp_read and last_grant. last_grant resets to DATA.
- While RST is high: all gnt, rvalid and err outputs are 0, rdata outputs are 0, ram_en_o=0 and ram_we_o=0.
- Grant is combinational in the request cycle; there is no idle/busy state. A new grant is legal every cycle, so throughput is one transaction per cycle.
- Arbitration when both ports request: the winner is granted; the loser sees gnt=0 and keeps req high, per the Ibex protocol. Request attributes may change only after gnt.
- In range: addr[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2]. addr[1:0] is ignored.
- Granted and in range:
  - ram_en_o=1, ram_a_o=addr[ADDR_W+1:2].
  - ram_we_o=data_be_i if the data port is writing, otherwise 4'b0000. The instruction port never writes.
  - ram_di_o=data_wdata_i.
- Granted and out of range: ram_en_o=0, ram_we_o=0, resp_err=1.
- Not granted: ram_en_o=0, ram_we_o=0. ram_a_o and ram_di_o are don't-care but are driven from the data port.
- Response register: on each grant, resp_valid=1, resp_port=winner, resp_read=!write, resp_err=range_fail. With no grant, resp_valid=0.
- Response timing: exactly one cycle after grant, <port>_rvalid_o=1 for resp_port only.
  - err_o=resp_err.
  - rdata_o=ram_do_i if resp_read and !resp_err, otherwise 32'h0.
  - The non-selected port's rvalid, err and rdata are all 0.
- Write then read of the same word on consecutive grants: the read returns the newly written data, because the RAM write commits at the grant edge.
- Reset mid-transaction: a pending response is dropped and no rvalid follows. The core is reset alongside.
- There is no response back-pressure: the Ibex rvalid has no ready.

Optional Feature:
- Macro: DFFRAM_ARB_RR_EN.
- Defined: round-robin arbitration.
  - On contention, grant the port opposite last_grant.
  - last_grant updates on every grant, contended or not.
- Undefined: fixed priority, data over instr. Instruction fetch may starve under continuous LSU traffic; this is accepted. The last_grant flop is removed.

Test Plan:
- Preload word 4 = 32'hDEADBEEF; instr req addr 0x10 -> same cycle instr_gnt_o=1, ram_en_o=1, ram_a_o=4, ram_we_o=0; next cycle instr_rvalid_o=1, rdata=32'hDEADBEEF, err=0, data_rvalid_o=0.
- Word 8 = 32'hFFFFFFFF; data write addr 0x20, be=4'b0101, wdata=32'h11223344 -> ram_we_o=4'b0101, next-cycle data_rvalid_o=1 with rdata=0. Read 0x20 on the next cycle -> 32'hFF22FF44.
- Both ports request continuously for 4 cycles. Without the macro -> grants D,D,D,D and instr_gnt_o=0 throughout. With DFFRAM_ARB_RR_EN -> grants I,D,I,D, with rvalids alternating one cycle later.
- Data read addr 0x0000_4000 (BASE 0, ADDR_W 12) -> gnt=1, ram_en_o=0; next cycle data_rvalid_o=1, data_err_o=1, rdata=0.
- Data read gets its grant, then RST is asserted before the next edge -> no rvalid on any port afterwards. All outputs are 0 while RST is high. The first request after reset is served normally.
- Back-to-back grants: instr read 0x0, data read 0x4, instr read 0x8 on consecutive cycles -> three consecutive rvalids on the matching ports with the correct words.
